// File: rtl/compute_hash_pkg.sv
// rtl/compute_hash_pkg.sv - shared SHA-256 constants, FSM encoding and helper functions
package compute_hash_pkg;

    localparam int MSG_LENGTH_DEF  = 16;
    localparam int HASH_LENGTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROUND  = 3'd2,
        ST_FINAL  = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Eight 32-bit words; element i sits at bits [32i+31:32i], so element 0 is a / H0.
    typedef logic [7:0][31:0] sha_state_t;

    localparam sha_state_t H_INIT = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/compute_hash_if.sv
// rtl/compute_hash_if.sv - message-memory read port and digest output bundle
// master: the hashing core (drives addresses, strobes and digest, receives m_data)
// slave : memory / downstream store stage
//   m_data                 32-bit message word, valid one cycle after m_address
//   m_address, m_read      message word read address and strobe
//   hash_vector            digest, word i at [32i+31:32i]
//   h_address              hash word index for the store stage
//   address_read_complete  all hash word indices issued
//   hash_enable            digest valid / downstream enable
interface compute_hash_if #(
    parameter int MSG_LENGTH  = 16,
    parameter int HASH_LENGTH = 8
);
    localparam int MAW = $clog2(MSG_LENGTH);
    localparam int HAW = $clog2(HASH_LENGTH);

    logic [31:0]               m_data;
    logic [MAW-1:0]            m_address;
    logic                      m_read;
    logic [32*HASH_LENGTH-1:0] hash_vector;
    logic [HAW-1:0]            h_address;
    logic                      address_read_complete;
    logic                      hash_enable;

    modport master (
        input  m_data,
        output m_address, m_read, hash_vector, h_address, address_read_complete, hash_enable
    );

    modport slave (
        output m_data,
        input  m_address, m_read, hash_vector, h_address, address_read_complete, hash_enable
    );
endinterface

// File: rtl/compute_hash_round.sv
// rtl/compute_hash_round.sv - combinational single SHA-256 compression round
// Ports:
//   vars_in   working variables a..h (element 0 = a)
//   w_t, k_t  schedule word and round constant for this round
//   vars_out  working variables after the round
module sha256_round
    import compute_hash_pkg::*;
(
    input  sha_state_t  vars_in,
    input  logic [31:0] w_t,
    input  logic [31:0] k_t,
    output sha_state_t  vars_out
);
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] ch, maj, t1, t2;

    assign {h, g, f, e, d, c, b, a} = vars_in;

    always_comb begin
        ch  = (e & f) ^ (~e & g);
        maj = (a & b) ^ (a & c) ^ (b & c);
        t1  = h + big_sigma1(e) + ch + k_t + w_t;
        t2  = big_sigma0(a) + maj;
        vars_out = {g, f, e, d + t1, c, b, a, t1 + t2};
    end
endmodule

// File: rtl/compute_hash.sv
// rtl/compute_hash.sv - single-block SHA-256 engine with message fetch and digest index sequencing
// Ports:
//   clock   rising-edge clock
//   reset   asynchronous active-low reset
//   enable  start/hold; low returns to IDLE on the next edge
//   bus     compute_hash_if.master (message read port, digest and store-stage indices)
module compute_hash
    import compute_hash_pkg::*;
#(
    parameter int MSG_LENGTH  = MSG_LENGTH_DEF,
    parameter int HASH_LENGTH = HASH_LENGTH_DEF
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    compute_hash_if.master bus
);
    localparam int MAW = $clog2(MSG_LENGTH);
    localparam int HAW = $clog2(HASH_LENGTH);
    localparam int LCW = MAW + 1;
    localparam int WIN = 16;

    state_t         state, next_state;
    logic [LCW-1:0] load_cnt;
    logic [5:0]     round_cnt;
    logic [HAW-1:0] h_cnt;
    logic [31:0]    w_win [WIN];
    logic [31:0]    w_next;
    sha_state_t     vars, vars_next, hash_q;
    logic           m_read_c, hash_enable_c, arc_c;

    // The window always holds W[t..t+15] during ROUND, so w_win[0] is the
    // current round's word and the freshly computed W[t+16] is shifted in.
    assign w_next = small_sigma1(w_win[14]) + w_win[9] + small_sigma0(w_win[1]) + w_win[0];

    sha256_round u_round (
        .vars_in  (vars),
        .w_t      (w_win[0]),
        .k_t      (K_TABLE[round_cnt]),
        .vars_out (vars_next)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   next_state = ST_LOAD;
                ST_LOAD:   if (load_cnt == LCW'(MSG_LENGTH)) next_state = ST_ROUND;
                ST_ROUND:  if (round_cnt == 6'd63) next_state = ST_FINAL;
                ST_FINAL:  next_state = ST_OUTPUT;
                ST_OUTPUT: if (h_cnt == HAW'(HASH_LENGTH - 1)) next_state = ST_DONE;
                ST_DONE:   next_state = ST_DONE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        m_read_c      = 1'b0;
        hash_enable_c = 1'b0;
        arc_c         = 1'b0;
        case (state)
            // The final LOAD cycle only captures the last word; no new read.
            ST_LOAD:   m_read_c = (load_cnt < LCW'(MSG_LENGTH));
            ST_OUTPUT: hash_enable_c = 1'b1;
            ST_DONE: begin
                hash_enable_c = 1'b1;
                arc_c         = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            load_cnt  <= '0;
            round_cnt <= '0;
            h_cnt     <= '0;
            vars      <= '0;
            hash_q    <= '0;
            for (int i = 0; i < WIN; i++) w_win[i] <= '0;
        end else if (next_state == ST_IDLE) begin
            // Abort or completion: sequencing restarts from scratch, digest kept.
            load_cnt  <= '0;
            round_cnt <= '0;
            h_cnt     <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    load_cnt <= load_cnt + LCW'(1);
                    // Data for address n arrives while load_cnt == n+1.
                    if (load_cnt != '0) begin
                        for (int i = 0; i < WIN - 1; i++) w_win[i] <= w_win[i+1];
                        w_win[WIN-1] <= bus.m_data;
                    end
                    if (load_cnt == LCW'(MSG_LENGTH)) vars <= H_INIT;
                end
                ST_ROUND: begin
                    vars      <= vars_next;
                    round_cnt <= round_cnt + 6'd1;
                    for (int i = 0; i < WIN - 1; i++) w_win[i] <= w_win[i+1];
                    w_win[WIN-1] <= w_next;
                end
                ST_FINAL: begin
                    for (int i = 0; i < 8; i++) hash_q[i] <= H_INIT[i] + vars[i];
                end
                ST_OUTPUT: begin
                    if (h_cnt != HAW'(HASH_LENGTH - 1)) h_cnt <= h_cnt + HAW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.m_address             = load_cnt[MAW-1:0];
    assign bus.m_read                = m_read_c;
    assign bus.hash_vector           = hash_q;
    assign bus.h_address             = h_cnt;
    assign bus.address_read_complete = arc_c;
    assign bus.hash_enable           = hash_enable_c;
endmodule

// File: tb/tb_compute_hash.sv
// tb/tb_compute_hash.sv - directed vector bench for compute_hash
module tb_compute_hash;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] mem [16];

    typedef struct packed {
        logic [511:0] block;
        logic [255:0] digest;
    } vec_t;
    vec_t vecs [3];

    compute_hash_if #(.MSG_LENGTH(16), .HASH_LENGTH(8)) bus ();

    compute_hash #(.MSG_LENGTH(16), .HASH_LENGTH(8)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    // Synchronous message memory: word appears the cycle after its address.
    always @(posedge clock) begin
        if (bus.m_read) bus.m_data <= mem[bus.m_address];
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Standard big-endian digest (H0 first) -> hash_vector layout (H0 at [31:0]).
    function automatic logic [255:0] to_hv(input logic [255:0] be);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = be[255-32*i -: 32];
        return r;
    endfunction

    function automatic logic [255:0] small_outs();
        return 256'({bus.m_read, bus.m_address, bus.h_address, bus.hash_enable, bus.address_read_complete});
    endfunction

    // Starts from IDLE at a negedge, leaves the DUT in DONE with enable high.
    task automatic run_block(input logic [511:0] blk, input logic [255:0] exp_hv,
                             input logic [255:0] prev_hv, input int tag);
        int n;
        int seq_err;
        bit found;
        for (int i = 0; i < 16; i++) mem[i] = blk[511-32*i -: 32];
        enable = 1'b1;
        n = 0;
        seq_err = 0;
        found = 1'b0;
        while (n < 200 && !found) begin
            @(negedge clock);
            n++;
            if (n >= 1 && n <= 16 && (bus.m_read !== 1'b1 || bus.m_address !== 4'(n - 1))) seq_err++;
            if (n == 17 && bus.m_read !== 1'b0) seq_err++;
            if (n == 10) check($sformatf("v%0d_prev_digest_held_in_load", tag), bus.hash_vector, prev_hv);
            if (bus.hash_enable === 1'b1) found = 1'b1;
        end
        check($sformatf("v%0d_load_addr_seq_errors", tag), 256'(seq_err), 256'(0));
        check($sformatf("v%0d_latency", tag), 256'(n), 256'(83));
        check($sformatf("v%0d_digest", tag), bus.hash_vector, exp_hv);
        seq_err = 0;
        for (int j = 0; j < 8; j++) begin
            if (bus.h_address !== 3'(j) || bus.hash_enable !== 1'b1 || bus.address_read_complete !== 1'b0)
                seq_err++;
            @(negedge clock);
        end
        check($sformatf("v%0d_h_addr_seq_errors", tag), 256'(seq_err), 256'(0));
        seq_err = 0;
        for (int j = 0; j < 3; j++) begin
            if (bus.h_address !== 3'd7 || bus.address_read_complete !== 1'b1 || bus.hash_enable !== 1'b1)
                seq_err++;
            @(negedge clock);
        end
        check($sformatf("v%0d_done_hold_errors", tag), 256'(seq_err), 256'(0));
    endtask

    initial begin
        logic [255:0] prev;
        logic [255:0] abc_hv;

        vecs[0].block  = {32'h61626380, 448'h0, 32'h00000018};
        vecs[0].digest = to_hv(256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        vecs[1].block  = {32'h80000000, 480'h0};
        vecs[1].digest = to_hv(256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
        vecs[2].block  = {32'h54686520, 32'h71756963, 32'h6b206272, 32'h6f776e20,
                          32'h666f7820, 32'h6a756d70, 32'h73206f76, 32'h65722074,
                          32'h6865206c, 32'h617a7920, 32'h646f6780, 128'h0, 32'h00000158};
        vecs[2].digest = to_hv(256'hd7a8fbb3_07d78094_69ca9abc_b0082e4f_8d5651e4_6d3cdb76_2d02d0bf_37c9e592);
        abc_hv = vecs[0].digest;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_hash_vector", bus.hash_vector, 256'h0);
        check("reset_ctrl_outputs", small_outs(), 256'h0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_waits_for_enable", small_outs(), 256'h0);

        // Table of blocks, applied back-to-back with a one-cycle enable drop
        prev = 256'h0;
        for (int v = 0; v < 3; v++) begin
            run_block(vecs[v].block, vecs[v].digest, prev, v);
            prev = vecs[v].digest;
            enable = 1'b0;
            @(negedge clock);
            check($sformatf("v%0d_idle_clears_ctrl", v), small_outs(), 256'h0);
            check($sformatf("v%0d_idle_keeps_digest", v), bus.hash_vector, prev);
        end

        // Abort at round 30, then restart with "abc"
        for (int i = 0; i < 16; i++) mem[i] = vecs[0].block[511-32*i -: 32];
        enable = 1'b1;
        repeat (48) @(negedge clock);
        enable = 1'b0;
        @(negedge clock);
        check("abort_hash_enable_low", 256'(bus.hash_enable), 256'h0);
        check("abort_keeps_digest", bus.hash_vector, prev);
        repeat (3) @(negedge clock);
        check("abort_stays_idle", small_outs(), 256'h0);
        run_block(vecs[0].block, abc_hv, prev, 10);

        // Asynchronous reset mid-LOAD
        enable = 1'b0;
        @(negedge clock);
        enable = 1'b1;
        repeat (5) @(negedge clock);
        check("pre_reset_in_load", 256'(bus.m_read), 256'h1);
        @(posedge clock);
        #2;
        reset = 1'b0;
        enable = 1'b0;
        #1;
        check("async_reset_ctrl", small_outs(), 256'h0);
        check("async_reset_digest", bus.hash_vector, 256'h0);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("post_reset_waits", small_outs(), 256'h0);
        run_block(vecs[0].block, abc_hv, 256'h0, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end
endmodule
